// File: rtl/config_loader_pkg.sv
// Shared sizing constants and sequencer state encoding for the tile
// configuration loader.
package config_loader_pkg;

   localparam int DATA_W    = 32;
   localparam int NUM_WORDS = 35;
   localparam int IDX_W     = 6;
   localparam int CFG_W     = DATA_W * NUM_WORDS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_WORD,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_DONE
   } state_t;

endpackage

// File: rtl/config_loader_onehot_decoder.sv
// Index-to-one-hot latch enable decoder; all outputs forced low when i_en=0.
module onehot_decoder
   import config_loader_pkg::*;
#(
   parameter int SEL_W   = IDX_W,
   parameter int NUM_OUT = NUM_WORDS
) (
   input  logic [SEL_W-1:0]   i_idx,
   input  logic               i_en,
   output logic [NUM_OUT-1:0] o_onehot
);

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_dec
      assign o_onehot[g] = i_en && (i_idx == SEL_W'(g));
   end

endmodule

// File: rtl/config_loader.sv
// Sequences 32-bit config words into a transparent-latch bank, keeping the
// data bus stable for a full cycle on each side of every enable pulse.
module config_loader
   import config_loader_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_start,
   input  logic                 io_in_valid,
   output logic                 io_in_ready,
   input  logic [DATA_W-1:0]    io_in_bits,
   output logic [DATA_W-1:0]    io_d_out,
   output logic [NUM_WORDS-1:0] io_configs_en,
   output logic                 io_busy,
   output logic                 io_done
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_index;
   logic [IDX_W-1:0]      w_index_nxt;
   logic                  w_accept;
   logic                  w_last;
   logic [NUM_WORDS-1:0]  w_en_nxt;

   logic                  r_ready;
   logic                  r_busy;
   logic                  r_done;
   logic [DATA_W-1:0]     r_d_out;
   logic [NUM_WORDS-1:0]  r_en;

   assign w_accept = (r_state == S_WAIT_WORD) && r_ready && io_in_valid;
   assign w_last   = (r_index == IDX_W'(NUM_WORDS - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_index <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_index <= w_index_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_index_nxt = r_index;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (io_start) begin
               w_state_nxt = S_WAIT_WORD;
               w_index_nxt = '0;
            end
         end
         S_WAIT_WORD: begin
            if (w_accept) w_state_nxt = S_SETUP;
         end
         S_SETUP:  w_state_nxt = S_STROBE;
         S_STROBE: w_state_nxt = S_HOLD;
         S_HOLD: begin
            // Index saturates at the last slice; it is only reloaded by a start.
            if (w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_WAIT_WORD;
               w_index_nxt = r_index + IDX_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Index is unchanged from SETUP through STROBE, so decoding against the
   // next state yields a registered enable aligned with the STROBE cycle.
   onehot_decoder #(
      .SEL_W   (IDX_W),
      .NUM_OUT (NUM_WORDS)
   ) u_dec (
      .i_idx    (r_index),
      .i_en     (w_state_nxt == S_STROBE),
      .o_onehot (w_en_nxt)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_d_out <= '0;
         r_en    <= '0;
      end else begin
         r_ready <= (w_state_nxt == S_WAIT_WORD);
         r_busy  <= (w_state_nxt inside {S_WAIT_WORD, S_SETUP, S_STROBE, S_HOLD});
         r_done  <= (w_state_nxt == S_DONE);
         r_en    <= w_en_nxt;
         if (w_accept) r_d_out <= io_in_bits;
      end
   end

   assign io_in_ready   = r_ready;
   assign io_busy       = r_busy;
   assign io_done       = r_done;
   assign io_d_out      = r_d_out;
   assign io_configs_en = r_en;

endmodule
